// File: rtl/axi_pkg.sv
// AXI AW field widths and the fixed-width part of the AW beat; awid/awaddr widths are per-instance.
// Latency: n/a. Backpressure: n/a.
package axi_pkg;

    localparam int AXI_LEN_W   = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 2;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;

    typedef struct packed {
        logic [AXI_LEN_W-1:0]   awlen;
        logic [AXI_SIZE_W-1:0]  awsize;
        logic [AXI_BURST_W-1:0] awbrust;
        logic [AXI_LOCK_W-1:0]  awlock;
        logic [AXI_CACHE_W-1:0] awcache;
        logic [AXI_PROT_W-1:0]  awprot;
        logic [AXI_QOS_W-1:0]   awqos;
    } aw_ctl_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
// Latency: combinational. Backpressure: none.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin : pick
        int             c;
        logic           found;
        logic [IDX_W-1:0] cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = IDX_W'(c);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/axi_aw_arbiter.sv
// N:1 AXI AW arbiter, round-robin, one registered output slot; AXI_AW_ID_TAG_EN tags m_awid with the winner.
// Latency: 1 cycle requester handshake -> m_awvalid. Backpressure: req_awready only while slot free or draining.
module axi_aw_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_MAX_WIDTH = 12,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req_awvalid,
    output logic [NUM_REQ-1:0]                       req_awready,
    input  logic [NUM_REQ-1:0][ID_MAX_WIDTH-1:0]     req_awid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]       req_awaddr,
    input  logic [NUM_REQ-1:0][AXI_LEN_W-1:0]        req_awlen,
    input  logic [NUM_REQ-1:0][AXI_SIZE_W-1:0]       req_awsize,
    input  logic [NUM_REQ-1:0][AXI_BURST_W-1:0]      req_awbrust,
    input  logic [NUM_REQ-1:0][AXI_LOCK_W-1:0]       req_awlock,
    input  logic [NUM_REQ-1:0][AXI_CACHE_W-1:0]      req_awcache,
    input  logic [NUM_REQ-1:0][AXI_PROT_W-1:0]       req_awprot,
    input  logic [NUM_REQ-1:0][AXI_QOS_W-1:0]        req_awqos,
    output logic                                     m_awvalid,
    input  logic                                     m_awready,
    output logic [ID_MAX_WIDTH-1:0]                  m_awid,
    output logic [ADDR_WIDTH-1:0]                    m_awaddr,
    output logic [AXI_LEN_W-1:0]                     m_awlen,
    output logic [AXI_SIZE_W-1:0]                    m_awsize,
    output logic [AXI_BURST_W-1:0]                   m_awbrust,
    output logic [AXI_LOCK_W-1:0]                    m_awlock,
    output logic [AXI_CACHE_W-1:0]                   m_awcache,
    output logic [AXI_PROT_W-1:0]                    m_awprot,
    output logic [AXI_QOS_W-1:0]                     m_awqos,
    output logic [$clog2(NUM_REQ)-1:0]               grant_idx,
    output logic                                     grant_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ID_MAX_WIDTH-1:0] awid;
        logic [ADDR_WIDTH-1:0]   awaddr;
        aw_ctl_t                 ctl;
    } aw_t;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    aw_t              aw_q, aw_d;

    logic             hs, arb_en;
    logic [IDX_W-1:0] ptr_inc, arb_ptr, arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_MAX_WIDTH-1:0] sel_id;

    assign ptr_inc = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign hs      = (state_q == HOLD) && m_awready;
    assign arb_en  = (state_q == IDLE) || hs;
    // On a drain cycle the next winner is chosen with the pointer already advanced.
    assign arb_ptr = hs ? ptr_inc : rr_ptr_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req (req_awvalid),
        .ptr (arb_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

`ifdef AXI_AW_ID_TAG_EN
    assign sel_id = {arb_idx, req_awid[arb_idx][ID_MAX_WIDTH-IDX_W-1:0]};
`else
    assign sel_id = req_awid[arb_idx];
`endif

    assign req_awready = (arb_en && rst_n) ? arb_gnt : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        aw_d     = aw_q;
        if (hs) begin
            rr_ptr_d = ptr_inc;
            state_d  = IDLE;
        end
        if (arb_en && (|req_awvalid)) begin
            state_d             = HOLD;
            idx_d               = arb_idx;
            aw_d.awid           = sel_id;
            aw_d.awaddr         = req_awaddr[arb_idx];
            aw_d.ctl.awlen      = req_awlen[arb_idx];
            aw_d.ctl.awsize     = req_awsize[arb_idx];
            aw_d.ctl.awbrust    = req_awbrust[arb_idx];
            aw_d.ctl.awlock     = req_awlock[arb_idx];
            aw_d.ctl.awcache    = req_awcache[arb_idx];
            aw_d.ctl.awprot     = req_awprot[arb_idx];
            aw_d.ctl.awqos      = req_awqos[arb_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            aw_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            aw_q     <= aw_d;
        end
    end

    assign m_awvalid  = (state_q == HOLD);
    assign grant_done = hs;
    assign grant_idx  = idx_q;
    assign m_awid     = aw_q.awid;
    assign m_awaddr   = aw_q.awaddr;
    assign m_awlen    = aw_q.ctl.awlen;
    assign m_awsize   = aw_q.ctl.awsize;
    assign m_awbrust  = aw_q.ctl.awbrust;
    assign m_awlock   = aw_q.ctl.awlock;
    assign m_awcache  = aw_q.ctl.awcache;
    assign m_awprot   = aw_q.ctl.awprot;
    assign m_awqos    = aw_q.ctl.awqos;

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Directed vector bench for axi_aw_arbiter: one table row per cycle plus a mid-HOLD reset sequence.
module tb_axi_aw_arbiter;

    localparam int N  = 4;
    localparam int IW = 12;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]          req_awvalid, req_awready;
    logic [N-1:0][IW-1:0]  req_awid;
    logic [N-1:0][AW-1:0]  req_awaddr;
    logic [N-1:0][3:0]     req_awlen;
    logic [N-1:0][2:0]     req_awsize;
    logic [N-1:0][1:0]     req_awbrust;
    logic [N-1:0][1:0]     req_awlock;
    logic [N-1:0][3:0]     req_awcache;
    logic [N-1:0][2:0]     req_awprot;
    logic [N-1:0][3:0]     req_awqos;
    logic                  m_awvalid, m_awready;
    logic [IW-1:0]         m_awid;
    logic [AW-1:0]         m_awaddr;
    logic [3:0]            m_awlen;
    logic [2:0]            m_awsize;
    logic [1:0]            m_awbrust;
    logic [1:0]            m_awlock;
    logic [3:0]            m_awcache;
    logic [2:0]            m_awprot;
    logic [3:0]            m_awqos;
    logic [1:0]            grant_idx;
    logic                  grant_done;

    axi_aw_arbiter #(.NUM_REQ(N), .ID_MAX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_awvalid(req_awvalid), .req_awready(req_awready),
        .req_awid(req_awid), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
        .req_awsize(req_awsize), .req_awbrust(req_awbrust), .req_awlock(req_awlock),
        .req_awcache(req_awcache), .req_awprot(req_awprot), .req_awqos(req_awqos),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awbrust(m_awbrust), .m_awlock(m_awlock), .m_awcache(m_awcache),
        .m_awprot(m_awprot), .m_awqos(m_awqos),
        .grant_idx(grant_idx), .grant_done(grant_done)
    );

    typedef struct {
        logic [3:0] v;
        logic       mr;
        logic [3:0] rdy;
        logic       mv;
        logic [1:0] gidx;
        logic       gd;
        logic [1:0] ptr;
    } vec_t;

    vec_t          vecs[22];
    logic [IW-1:0] id_tbl[N];
    logic [IW-1:0] exp_id_tbl[N];
    logic [AW-1:0] addr_tbl[N];
    int            n_pass = 0;
    int            n_total = 0;

    function automatic vec_t mkv(logic [3:0] v, logic mr, logic [3:0] rdy, logic mv,
                                 logic [1:0] gidx, logic gd, logic [1:0] ptr);
        vec_t r;
        r.v = v; r.mr = mr; r.rdy = rdy; r.mv = mv; r.gidx = gidx; r.gd = gd; r.ptr = ptr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial begin
        id_tbl[0] = 12'h001; id_tbl[1] = 12'h002; id_tbl[2] = 12'h003; id_tbl[3] = 12'h005;
`ifdef AXI_AW_ID_TAG_EN
        exp_id_tbl[0] = 12'h001; exp_id_tbl[1] = 12'h402; exp_id_tbl[2] = 12'h803; exp_id_tbl[3] = 12'hC05;
`else
        exp_id_tbl[0] = 12'h001; exp_id_tbl[1] = 12'h002; exp_id_tbl[2] = 12'h003; exp_id_tbl[3] = 12'h005;
`endif
        addr_tbl[0] = 32'h0000_A000; addr_tbl[1] = 32'h0000_B000;
        addr_tbl[2] = 32'h0000_1000; addr_tbl[3] = 32'h0000_D000;
        for (int i = 0; i < N; i++) begin
            req_awid[i]    = id_tbl[i];
            req_awaddr[i]  = addr_tbl[i];
            req_awlen[i]   = 4'(i);
            req_awsize[i]  = 3'd2;
            req_awbrust[i] = 2'b01;
            req_awlock[i]  = 2'b00;
            req_awcache[i] = 4'h3;
            req_awprot[i]  = 3'd0;
            req_awqos[i]   = 4'(15 - i);
        end

        //            v        mr    rdy      mv    gidx  gd    ptr
        vecs[0]  = mkv(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
        vecs[1]  = mkv(4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 2'd0);
        vecs[2]  = mkv(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd0);
        vecs[3]  = mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd3);
        vecs[4]  = mkv(4'b1111, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0, 2'd3);
        vecs[5]  = mkv(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1, 2'd3);
        vecs[6]  = mkv(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1, 2'd0);
        vecs[7]  = mkv(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1, 2'd1);
        vecs[8]  = mkv(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1, 2'd2);
        vecs[9]  = mkv(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1, 2'd3);
        for (int i = 10; i <= 14; i++)
            vecs[i] = mkv(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0);
        vecs[15] = mkv(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1, 2'd0);
        vecs[16] = mkv(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1);
        vecs[17] = mkv(4'b1001, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0, 2'd2);
        vecs[18] = mkv(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1, 2'd2);
        vecs[19] = mkv(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd0);
        vecs[20] = mkv(4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 2'd1);
        vecs[21] = mkv(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd1);

        req_awvalid = '0;
        m_awready   = 1'b0;

        // Reset values while reset is held.
        #7;
        chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_req_awready", 64'(req_awready), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        chk("rst_grant_done", 64'(grant_done), 64'd0);
        chk("rst_m_awaddr", 64'(m_awaddr), 64'd0);
        chk("rst_m_awid", 64'(m_awid), 64'd0);
        chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 22; r++) begin
            req_awvalid = vecs[r].v;
            m_awready   = vecs[r].mr;
            #1;
            chk($sformatf("row%0d_req_awready", r), 64'(req_awready), 64'(vecs[r].rdy));
            chk($sformatf("row%0d_m_awvalid", r), 64'(m_awvalid), 64'(vecs[r].mv));
            chk($sformatf("row%0d_grant_done", r), 64'(grant_done), 64'(vecs[r].gd));
            chk($sformatf("row%0d_rr_ptr", r), 64'(dut.rr_ptr_q), 64'(vecs[r].ptr));
            if (vecs[r].mv) begin
                chk($sformatf("row%0d_grant_idx", r), 64'(grant_idx), 64'(vecs[r].gidx));
                chk($sformatf("row%0d_m_awaddr", r), 64'(m_awaddr), 64'(addr_tbl[vecs[r].gidx]));
                chk($sformatf("row%0d_m_awid", r), 64'(m_awid), 64'(exp_id_tbl[vecs[r].gidx]));
                chk($sformatf("row%0d_m_awlen", r), 64'(m_awlen), 64'(vecs[r].gidx));
                chk($sformatf("row%0d_m_awqos", r), 64'(m_awqos), 64'(4'd15 - 4'(vecs[r].gidx)));
            end
            @(negedge clk);
        end

        // Reset in the middle of HOLD with requester 1's address pending.
        req_awvalid = 4'b0010;
        m_awready   = 1'b0;
        #1;
        chk("mid_req_awready", 64'(req_awready), 64'b0010);
        @(negedge clk);
        #1;
        chk("mid_hold_m_awvalid", 64'(m_awvalid), 64'd1);
        chk("mid_hold_grant_idx", 64'(grant_idx), 64'd1);
        chk("mid_hold_m_awaddr", 64'(m_awaddr), 64'(addr_tbl[1]));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_awvalid", 64'(m_awvalid), 64'd0);
        chk("mid_rst_req_awready", 64'(req_awready), 64'd0);
        chk("mid_rst_grant_idx", 64'(grant_idx), 64'd0);
        chk("mid_rst_m_awaddr", 64'(m_awaddr), 64'd0);
        chk("mid_rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        req_awvalid = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        m_awready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("post_rst%0d_m_awvalid", c), 64'(m_awvalid), 64'd0);
            chk($sformatf("post_rst%0d_grant_done", c), 64'(grant_done), 64'd0);
            @(negedge clk);
        end
        // Pointer restarted at 0: requester 0 beats requester 1.
        req_awvalid = 4'b0011;
        #1;
        chk("post_rst_req_awready", 64'(req_awready), 64'b0001);
        @(negedge clk);
        req_awvalid = '0;
        #1;
        chk("post_rst_grant_idx", 64'(grant_idx), 64'd0);
        chk("post_rst_m_awaddr", 64'(m_awaddr), 64'(addr_tbl[0]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
